// File: rtl/audio_pkg.sv
// audio_pkg: note codes, effect ids, effect lengths and note sequences shared by the audio arbiter
package audio_pkg;
  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_L_C = 5'd1, NOTE_L_D = 5'd2, NOTE_L_E = 5'd3, NOTE_L_F = 5'd4;
  localparam logic [4:0] NOTE_L_G = 5'd5, NOTE_L_GS = 5'd6, NOTE_L_A = 5'd7, NOTE_L_B = 5'd8;
  localparam logic [4:0] NOTE_M_C = 5'd9, NOTE_M_D = 5'd10, NOTE_M_E = 5'd11, NOTE_M_F = 5'd12;
  localparam logic [4:0] NOTE_M_G = 5'd13, NOTE_M_GS = 5'd14, NOTE_M_A = 5'd15, NOTE_M_B = 5'd16;
  localparam logic [1:0] SFX_NONE = 2'd0, SFX_DROP = 2'd1, SFX_CLEAR = 2'd2, SFX_OVER = 2'd3;
  localparam int LEN_DROP = 2, LEN_CLEAR = 4, LEN_OVER = 8;
  localparam logic [1:0][4:0] DROP_SEQ = {NOTE_L_C, NOTE_L_G};
  localparam logic [3:0][4:0] CLEAR_SEQ = {NOTE_M_B, NOTE_M_G, NOTE_M_E, NOTE_M_C};
  localparam logic [7:0][4:0] OVER_SEQ = {NOTE_L_C, NOTE_L_E, NOTE_L_G, NOTE_L_A,
                                          NOTE_L_B, NOTE_M_C, NOTE_M_D, NOTE_M_E};
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  function automatic logic [1:0] top_id(input logic [2:0] v);
    return v[2] ? SFX_OVER : v[1] ? SFX_CLEAR : v[0] ? SFX_DROP : SFX_NONE;
  endfunction
  function automatic logic [2:0] last_step(input logic [1:0] id);
    return id == SFX_OVER ? 3'(LEN_OVER - 1) : id == SFX_CLEAR ? 3'(LEN_CLEAR - 1) : 3'(LEN_DROP - 1);
  endfunction
endpackage

// File: rtl/sfx_rom.sv
// sfx_rom: combinational (effect id, step) to note-code lookup; out-of-range steps return rest
module sfx_rom
  import audio_pkg::*;
(
  input  logic [1:0] id,
  input  logic [2:0] step,
  output logic [4:0] note
);
  always_comb
    note = id == SFX_OVER ? OVER_SEQ[step] :
           id == SFX_CLEAR && step < 3'(LEN_CLEAR) ? CLEAR_SEQ[step[1:0]] :
           id == SFX_DROP && step < 3'(LEN_DROP) ? DROP_SEQ[step[0]] : NOTE_REST;
endmodule

// File: rtl/audio_arbiter.sv
// audio_arbiter: shares the tone generator between music and sound effects.
// Define AUDIO_ARB_GAP_EN for one silent step between the final effect and resumed music.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int STEP_CYCLES = 3_125_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       music_en,
  input  logic [4:0] music_note,
  input  logic [2:0] level_in,
  input  logic       evt_drop,
  input  logic       evt_clear,
  input  logic       evt_over,
  output logic [4:0] note_out,
  output logic [2:0] level_out,
  output logic       sfx_busy,
  output logic [1:0] sfx_id
);
  localparam int CW = $clog2(STEP_CYCLES);
`ifdef AUDIO_ARB_GAP_EN
  localparam state_t DONE = GAP;
`else
  localparam state_t DONE = IDLE;
`endif
  state_t state, state_n;
  logic [1:0] id, id_n, start_id;
  logic [2:0] step, step_n, pend, pend_n, evt, req;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] rom_note;
  logic tick, last, start;
  sfx_rom u_rom (.id(id_n), .step(step_n), .note(rom_note));
  // Pending bits never outrank the playing effect, so only a fresh event can preempt mid-effect.
  always_comb begin
    evt = {evt_over, evt_clear, evt_drop};
    req = pend | evt;
    tick = cnt == CW'(STEP_CYCLES - 1);
    last = state == PLAY && tick && step == last_step(id);
    start_id = state == PLAY && !last ? (top_id(evt) > id ? top_id(evt) : SFX_NONE) : top_id(req);
    start = start_id != SFX_NONE;
    state_n = start ? PLAY : last ? DONE : state == GAP && tick ? IDLE : state;
    cnt_n = start || state == IDLE || tick ? '0 : cnt + 1'b1;
    step_n = start || state != PLAY || last ? '0 : step + 3'(tick);
    id_n = start ? start_id : state == PLAY && !last ? id : SFX_NONE;
    pend_n = start ? req & ~(3'b001 << (start_id - 2'd1)) &
                     (evt_over && start_id == SFX_OVER ? 3'b100 : 3'b111) : req;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      id <= SFX_NONE;
      step <= '0;
      cnt <= '0;
      pend <= '0;
      note_out <= NOTE_REST;
      level_out <= '0;
      sfx_busy <= 1'b0;
      sfx_id <= SFX_NONE;
    end else begin
      state <= state_n;
      id <= id_n;
      step <= step_n;
      cnt <= cnt_n;
      pend <= pend_n;
      note_out <= state_n == PLAY ? rom_note :
                  state_n == IDLE && music_en && music_note <= NOTE_M_B ? music_note : NOTE_REST;
      level_out <= level_in;
      sfx_busy <= state_n != IDLE;
      sfx_id <= id_n;
    end
endmodule

// File: tb/tb_audio_arbiter.sv
// tb_audio_arbiter: directed stimulus, elapsed-time reference model checked every cycle, plus literal pins
module tb_audio_arbiter;
  localparam int S = 4;
`ifdef AUDIO_ARB_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  logic clk = 0, rst = 0, music_en = 0, evt_drop = 0, evt_clear = 0, evt_over = 0;
  logic [4:0] music_note = 0;
  logic [2:0] level_in = 3'd5;
  logic [4:0] note_out;
  logic [2:0] level_out;
  logic sfx_busy;
  logic [1:0] sfx_id;
  int n_err = 0, n_chk = 0;
  bit chk_en = 0;
  int m_id = 0, m_t = 0, m_gap = 0;
  bit [3:1] m_pend = 0;
  int e_note = 0, e_level = 0, e_busy = 0, e_id = 0;
  int drop_seq[2] = '{5, 1};
  int clear_seq[4] = '{9, 11, 13, 16};
  int over_seq[8] = '{11, 10, 9, 8, 7, 5, 3, 1};

  audio_arbiter #(.STEP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .music_en(music_en), .music_note(music_note), .level_in(level_in),
    .evt_drop(evt_drop), .evt_clear(evt_clear), .evt_over(evt_over),
    .note_out(note_out), .level_out(level_out), .sfx_busy(sfx_busy), .sfx_id(sfx_id)
  );

  always #5 clk = ~clk;

  function automatic int top(input bit [3:1] v);
    return v[3] ? 3 : v[2] ? 2 : v[1] ? 1 : 0;
  endfunction
  function automatic int len(input int id);
    return id == 3 ? 8 : id == 2 ? 4 : 2;
  endfunction
  function automatic int rom(input int id, input int k);
    return id == 3 ? over_seq[k] : id == 2 ? clear_seq[k] : drop_seq[k];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_start(input int s, input bit [3:1] ev);
    m_pend |= ev;
    m_pend[s] = 1'b0;
    if (ev[3] && s == 3) m_pend[2:1] = 2'b00;
    m_id = s;
    m_t = 0;
    m_gap = 0;
  endtask

  task automatic model;
    bit [3:1] ev;
    ev = {evt_over, evt_clear, evt_drop};
    if (!rst) begin
      m_id = 0; m_t = 0; m_gap = 0; m_pend = 0;
      e_note = 0; e_level = 0; e_busy = 0; e_id = 0;
      return;
    end
    if (m_id != 0 && top(ev) > m_id) m_start(top(ev), ev);
    else if (m_id != 0) begin
      m_pend |= ev;
      m_t++;
      if (m_t == len(m_id) * S) begin
        if (m_pend != 0) m_start(top(m_pend), ev);
        else begin
          m_id = 0;
          m_gap = GAP ? S : 0;
        end
      end
    end else if (ev != 0) m_start(top(ev), ev);
    else if (m_gap > 0) m_gap--;
    e_id = m_id;
    e_busy = (m_id != 0 || m_gap > 0) ? 1 : 0;
    e_level = int'(level_in);
    e_note = m_id != 0 ? rom(m_id, m_t / S) :
             (m_gap == 0 && music_en && music_note <= 5'd16) ? int'(music_note) : 0;
  endtask

  initial forever begin
    @(posedge clk);
    model();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("note_out", note_out, e_note);
      check("level_out", level_out, e_level);
      check("sfx_busy", sfx_busy, e_busy);
      check("sfx_id", sfx_id, e_id);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input bit d, input bit c, input bit o);
    evt_drop = d; evt_clear = c; evt_over = o;
    cyc(1);
    evt_drop = 0; evt_clear = 0; evt_over = 0;
  endtask

  initial begin
    cyc(1);
    chk_en = 1;
    cyc(1);
    check("rst_note", note_out, 0);
    check("rst_level", level_out, 0);
    check("rst_busy", sfx_busy, 0);
    rst = 1; music_en = 1; music_note = 11;
    cyc(1);
    check("music_note", note_out, 11);
    check("music_level", level_out, 5);
    music_en = 0;
    cyc(1);
    check("music_off", note_out, 0);
    music_en = 1; music_note = 20;
    cyc(1);
    check("music_high_rest", note_out, 0);
    music_note = 3;
    cyc(1);
    check("music_low", note_out, 3);
    pulse(1, 0, 0);
    check("drop_s0", note_out, 5);
    check("drop_id", sfx_id, 1);
    cyc(3);
    check("drop_s0_end", note_out, 5);
    cyc(1);
    check("drop_s1", note_out, 1);
    cyc(3);
    check("drop_s1_end", note_out, 1);
    cyc(1);
    check("drop_after", note_out, GAP ? 0 : 3);
    cyc(4);
    check("drop_idle_busy", sfx_busy, 0);
    pulse(1, 0, 0);
    cyc(4);
    check("pre_drop_s1", note_out, 1);
    pulse(0, 0, 1);
    check("preempt_id", sfx_id, 3);
    check("preempt_note", note_out, 11);
    cyc(31);
    check("over_last", note_out, 1);
    cyc(GAP ? 5 : 1);
    check("no_drop_replay_id", sfx_id, 0);
    check("no_drop_replay_busy", sfx_busy, 0);
    pulse(1, 1, 0);
    check("simul_clear_id", sfx_id, 2);
    check("simul_clear_note", note_out, 9);
    cyc(5);
    pulse(1, 0, 0);
    cyc(9);
    check("clear_last", note_out, 16);
    cyc(1);
    check("drop_follows_id", sfx_id, 1);
    check("drop_follows_note", note_out, 5);
    cyc(7);
    check("drop_follows_last", note_out, 1);
    cyc(1);
    check("single_drop_id", sfx_id, 0);
    cyc(4);
    check("single_drop_busy", sfx_busy, 0);
    pulse(0, 1, 0);
    cyc(2);
    pulse(1, 0, 0);
    cyc(2);
    pulse(0, 0, 1);
    check("over_clr_id", sfx_id, 3);
    cyc(31);
    check("over_clr_last", note_out, 1);
    cyc(1);
    check("over_clr_no_drop", sfx_id, 0);
    cyc(4);
    check("over_clr_busy", sfx_busy, 0);
    pulse(0, 0, 1);
    cyc(12);
    check("rst_mid_note_pre", note_out, 8);
    rst = 0;
    cyc(1);
    check("rst_mid_note", note_out, 0);
    check("rst_mid_level", level_out, 0);
    check("rst_mid_busy", sfx_busy, 0);
    check("rst_mid_id", sfx_id, 0);
    rst = 1;
    cyc(1);
    check("post_rst_music", note_out, 3);
    cyc(40);
    check("post_rst_busy", sfx_busy, 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
